// File: rtl/serial_tx_4b.sv
// Serial transmitter for 4-bit words. Each frame is a start bit, four data bits LSB
// first, an even-parity bit and a stop bit, advancing one bit per bit_en strobe.
module serial_tx_4b (
   input  logic       clk,
   input  logic       rst,
   input  logic [3:0] data_in,
   input  logic       in_valid,
   output logic       in_ready,
   input  logic       bit_en,
   output logic       tx,
   output logic       busy,
   output logic       done
);

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      START  = 3'd1,
      DATA   = 3'd2,
      PARITY = 3'd3,
      STOP   = 3'd4
   } state_t;

   state_t     state, state_next;
   logic [1:0] bit_idx, bit_idx_next;
   logic [3:0] shadow, shadow_next;
   logic       tx_next;
   logic       done_next;
   logic [1:0] bit_idx_inc;

   // tx and done are flops so the line never glitches from input activity
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state   <= IDLE;
         bit_idx <= 2'd0;
         shadow  <= 4'd0;
         tx      <= 1'b1;
         done    <= 1'b0;
      end else begin
         state   <= state_next;
         bit_idx <= bit_idx_next;
         shadow  <= shadow_next;
         tx      <= tx_next;
         done    <= done_next;
      end
   end

   assign bit_idx_inc = bit_idx + 2'd1;

   // The load in IDLE does not wait for bit_en; every later step does
   always_comb begin
      state_next   = state;
      bit_idx_next = bit_idx;
      shadow_next  = shadow;
      tx_next      = tx;
      done_next    = 1'b0;
      case (state)
         IDLE: begin
            tx_next = 1'b1;
            if (in_valid) begin
               state_next  = START;
               shadow_next = data_in;
               tx_next     = 1'b0;
            end
         end
         START: begin
            if (bit_en) begin
               state_next   = DATA;
               bit_idx_next = 2'd0;
               tx_next      = shadow[0];
            end
         end
         DATA: begin
            if (bit_en) begin
               if (bit_idx == 2'd3) begin
                  state_next = PARITY;
                  tx_next    = ^shadow;
               end else begin
                  bit_idx_next = bit_idx_inc;
                  tx_next      = shadow[bit_idx_inc];
               end
            end
         end
         PARITY: begin
            if (bit_en) begin
               state_next = STOP;
               tx_next    = 1'b1;
            end
         end
         STOP: begin
            if (bit_en) begin
               state_next   = IDLE;
               bit_idx_next = 2'd0;
               tx_next      = 1'b1;
               done_next    = 1'b1;
            end
         end
         default: begin
            state_next = IDLE;
            tx_next    = 1'b1;
         end
      endcase
   end

   assign in_ready = (state == IDLE);
   assign busy     = (state != IDLE);

endmodule

// File: tb/tb_serial_tx_4b.sv
// Scoreboard bench for serial_tx_4b: stimulus pushes hand-computed bit sequences,
// a negedge monitor compares tx against them for every busy cycle.
module tb_serial_tx_4b;

   logic       clk;
   logic       rst;
   logic [3:0] data_in;
   logic       in_valid;
   logic       in_ready;
   logic       bit_en;
   logic       tx;
   logic       busy;
   logic       done;

   int compared   = 0;
   int mismatched = 0;
   bit exp_bits[$];
   int exp_done   = 0;

   serial_tx_4b dut (
      .clk      (clk),
      .rst      (rst),
      .data_in  (data_in),
      .in_valid (in_valid),
      .in_ready (in_ready),
      .bit_en   (bit_en),
      .tx       (tx),
      .busy     (busy),
      .done     (done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check_output(input string name, input logic [31:0] actual, input logic [31:0] expected);
      compared++;
      if (actual !== expected) begin
         mismatched++;
         $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, actual, expected, $time);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // seq[6] is the first bit on the line (start bit)
   task automatic push_frame(input logic [6:0] seq);
      for (int i = 6; i >= 0; i--) exp_bits.push_back(seq[i]);
      exp_done++;
   endtask

   task automatic wait_done(input string name);
      int n;
      n = 0;
      while (done !== 1'b1 && n < 40) begin
         step();
         n++;
      end
      if (done !== 1'b1) check_output({name, "_timeout"}, 32'd0, 32'd1);
   endtask

   task automatic apply_stimulus(input logic [3:0] d, input logic [6:0] seq);
      push_frame(seq);
      data_in  = d;
      in_valid = 1'b1;
      step();
      in_valid = 1'b0;
   endtask

   // The bit ending on the next edge is popped when bit_en is high
   always @(negedge clk) begin
      if (!rst) begin
         if (busy) begin
            if (exp_bits.size() == 0) begin
               check_output("unexpected_frame", 32'(busy), 32'd0);
            end else begin
               check_output("tx_bit", 32'(tx), 32'(exp_bits[0]));
               if (bit_en) void'(exp_bits.pop_front());
            end
         end
         if (done) begin
            if (exp_done == 0) begin
               check_output("done_unexpected", 32'(done), 32'd0);
            end else begin
               exp_done--;
               check_output("done_tx_idle", 32'(tx), 32'd1);
            end
         end
      end
   end

   initial begin
      #200000;
      $display("[TB] FAIL global_timeout: got running expected finished");
      $fatal(1, "[TB] timeout");
   end

   initial begin
      rst      = 1'b1;
      data_in  = 4'd0;
      in_valid = 1'b0;
      bit_en   = 1'b1;
      #23;
      check_output("reset_tx", 32'(tx), 32'd1);
      check_output("reset_busy", 32'(busy), 32'd0);
      check_output("reset_in_ready", 32'(in_ready), 32'd1);
      check_output("reset_done", 32'(done), 32'd0);
      step();
      rst = 1'b0;

      // Basic frame with bit_en tied high
      apply_stimulus(4'b1011, 7'b0110111);
      for (int i = 1; i <= 7; i++) begin
         check_output("basic_busy", 32'(busy), 32'd1);
         step();
      end
      check_output("basic_done_cycle8", 32'(done), 32'd1);
      check_output("basic_in_ready_cycle8", 32'(in_ready), 32'd1);
      step();
      check_output("basic_done_cleared", 32'(done), 32'd0);

      // Throttled: bit_en every third cycle, each bit held three cycles
      push_frame(7'b0011001);
      data_in  = 4'b0110;
      in_valid = 1'b1;
      bit_en   = 1'b0;
      step();
      in_valid = 1'b0;
      for (int i = 0; i < 7; i++) begin
         bit_en = 1'b0;
         step();
         step();
         bit_en = 1'b1;
         step();
      end
      bit_en = 1'b0;
      check_output("throttle_done", 32'(done), 32'd1);
      step();
      check_output("throttle_single_done", 32'(done), 32'd0);
      bit_en = 1'b1;
      step();

      // Back-to-back: in_valid held, second word loads on the done cycle
      push_frame(7'b0100011);
      push_frame(7'b0111101);
      data_in  = 4'b0001;
      in_valid = 1'b1;
      step();
      data_in = 4'b1111;
      wait_done("b2b_first");
      check_output("b2b_in_ready_on_done", 32'(in_ready), 32'd1);
      step();
      in_valid = 1'b0;
      check_output("b2b_no_gap_busy", 32'(busy), 32'd1);
      check_output("b2b_no_gap_start", 32'(tx), 32'd0);
      wait_done("b2b_second");
      step();

      // Interference while busy
      apply_stimulus(4'b0101, 7'b0101001);
      for (int n = 0; n < 20 && busy; n++) begin
         data_in  = ~data_in;
         in_valid = ~in_valid;
         step();
      end
      in_valid = 1'b0;
      check_output("interf_done", 32'(done), 32'd1);
      repeat (3) step();
      check_output("interf_no_extra_frame", 32'(busy), 32'd0);

      // Reset asynchronously during DATA(2)
      apply_stimulus(4'b1011, 7'b0110111);
      repeat (3) step();
      #2;
      rst = 1'b1;
      exp_bits.delete();
      exp_done--;
      #1;
      check_output("rst_mid_tx", 32'(tx), 32'd1);
      check_output("rst_mid_busy", 32'(busy), 32'd0);
      check_output("rst_mid_in_ready", 32'(in_ready), 32'd1);
      check_output("rst_mid_done", 32'(done), 32'd0);
      step();
      step();
      rst = 1'b0;
      check_output("post_rst_done", 32'(done), 32'd0);
      apply_stimulus(4'b1000, 7'b0000111);
      wait_done("post_rst_frame");
      step();

      // Idle strobes must be ignored
      bit_en = 1'b1;
      for (int i = 0; i < 10; i++) begin
         step();
         check_output("idle_tx", 32'(tx), 32'd1);
         check_output("idle_busy", 32'(busy), 32'd0);
         check_output("idle_done", 32'(done), 32'd0);
      end

      step();
      check_output("scoreboard_bits_drained", 32'(exp_bits.size()), 32'd0);
      check_output("scoreboard_done_drained", 32'(exp_done), 32'd0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule

// File: doc/serial_tx_4b.md
SERIAL_TX_4B -- requirements
Module: serial_tx_4b

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-high reset, named clk and rst.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 rst  input  1  asynchronous, active-high reset.
REQ-004 data_in  input  4  parallel word to transmit; sampled only on load.
REQ-005 in_valid  input  1  producer offers data_in.
REQ-006 in_ready  output  1  block can accept a word; high exactly when the FSM is in IDLE.
REQ-007 bit_en  input  1  bit-period strobe; the FSM advances only on edges where bit_en=1.
REQ-008 tx  output  1  registered serial line; idles high.
REQ-009 busy  output  1  high whenever the FSM is not in IDLE.
REQ-010 done  output  1  one-cycle pulse marking the end of a frame.

Function
REQ-011 Frame format SHALL be, in order:
- start bit (0);
- data_in[0], [1], [2], [3] (LSB first);
- even-parity bit (XOR of the 4 data bits);
- stop bit (1).
REQ-012 FSM states SHALL be IDLE, START, DATA, PARITY and STOP, with a 2-bit bit index used in DATA.
REQ-013 Load: on an edge with state=IDLE and in_valid=1:
- capture data_in into an internal 4-bit shadow register;
- next state=START, tx=0, busy=1, in_ready=0.
REQ-014 Transitions SHALL occur only on edges where bit_en=1:
- START->DATA(index 0);
- DATA(n)->DATA(n+1) for n<3;
- DATA(3)->PARITY;
- PARITY->STOP;
- STOP->IDLE.
REQ-015 With bit_en=0 the state and tx SHALL hold, so each bit lasts from state entry until the first edge with bit_en=1.
REQ-016 tx SHALL be driven from a flop and updated on the same edge as the state, never combinationally from inputs.
REQ-017 Timing with bit_en tied high:
- the frame occupies exactly 7 cycles after the load edge;
- tx is valid in cycles 1..7 after load.
REQ-018 done SHALL be 1 for exactly the one cycle after the STOP->IDLE edge, and 0 otherwise.
REQ-019 Back-to-back frames: in the cycle where done=1, in_ready=1, and a load on that edge SHALL start the next frame with no idle bit beyond the stop bit.
REQ-020 Changes on data_in or in_valid while busy=1 SHALL NOT affect the frame in progress and SHALL NOT be captured.
REQ-021 bit_en in IDLE SHALL be ignored; tx stays 1.
REQ-022 Simultaneous in_valid=1 and bit_en=1 in IDLE SHALL load; the first bit_en is not consumed by the load.
REQ-023 Parity SHALL be computed from the captured shadow register, not from the live data_in.

Reset
REQ-024 While rst=1, regardless of clk:
- state=IDLE, bit index=0, shadow register=0;
- tx=1, busy=0, in_ready=1, done=0.
REQ-025 rst asserted mid-frame SHALL abort the frame immediately:
- tx returns to 1 without waiting for a clock;
- no done pulse is produced.
REQ-026 After rst deasserts, the first edge SHALL behave as IDLE (load permitted).

Verification
REQ-027 Basic frame: rst pulse, then data_in=4'b1011, in_valid=1 for one cycle, bit_en=1 constantly.
- Required: tx = 0,1,1,0,1,1,1 on cycles 1..7.
- Required: done=1 on cycle 8; busy=1 on cycles 1..7.
REQ-028 Throttled: data_in=4'b0110 with bit_en=1 every 3rd cycle.
- Required: each tx bit is held 3 cycles; sequence 0,0,1,1,0,0(parity),1.
- Required: a single done pulse.
REQ-029 Back-to-back: load 4'b0001, hold in_valid=1 with data_in=4'b1111.
- Required: the second frame starts on the done cycle, giving tx 0,1,0,0,0,1,1 then 0,1,1,1,1,0,1 with no gap.
REQ-030 Interference: after loading 4'b0101, toggle data_in and in_valid every cycle while busy.
- Required: transmitted data bits stay 1,0,1,0 with parity 0.
- Required: no extra frame starts.
REQ-031 Reset mid-frame: assert rst asynchronously during DATA(2).
- Required: tx=1, busy=0, in_ready=1 before the next clk edge; done stays 0.
- Required: a following load of 4'b1000 transmits 0,0,0,0,1,1,1.
REQ-032 Idle strobes: bit_en=1 for 10 cycles with in_valid=0.
- Required: tx=1, busy=0 and done=0 throughout.
